// File: rtl/bsg_pkg.sv
// Shared definitions for the BSG receiver: register map, CONTROL bit
// positions, receive FSM state encoding and the Gray-to-binary helper.
package bsg_pkg;

  localparam logic [7:0] ADDR_CONTROL = 8'h00;
  localparam logic [7:0] ADDR_DATA0   = 8'h01;
  localparam logic [7:0] ADDR_DATA1   = 8'h02;

  localparam int CTRL_RXENABLE = 0;
  localparam int CTRL_INTMSK   = 1;
  localparam int CTRL_INTFLAG  = 2;
  localparam int CTRL_STATUS   = 3;
  localparam int CTRL_OVERRUN  = 4;
  localparam int CTRL_FRAMEERR = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_DATA0  = 3'd2,
    ST_DATA1  = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [7:0] gray_decode(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bsg_rx_if.sv
// Byte-wide register bus shared with the BSG transmitter.
// we = 0 writes Data_in to addr on the clock edge, we = 1 reads addr.
interface bsg_rx_if;
  logic [7:0] Data_in;
  logic [7:0] addr;
  logic       we;
  logic [7:0] Data_out;

  modport master (output Data_in, output addr, output we, input Data_out);
  modport slave  (input Data_in, input addr, input we, output Data_out);
endinterface

// File: rtl/gray_decoder.sv
// 8-bit combinational Gray-to-binary decoder; inverse of the transmitter's
// encoder.
module gray_decoder
  import bsg_pkg::*;
(
  input  logic [7:0] i_gray,
  output logic [7:0] o_bin
);

  assign o_bin = gray_decode(i_gray);

endmodule

// File: rtl/bsg_rx.sv
// BSG receiver: detects a sync symbol on the strobed RX_IN stream, samples
// two Gray-coded data symbols mid-symbol, decodes them into DATA_0/DATA_1
// and raises INTFLAG on each completed frame.
// Optional build macro: BSG_RX_STABLE_CHK_EN -- require every strobe of a
// symbol to match its first sample; a mismatch sets FRAMEERR and drops the
// frame. Without it FRAMEERR can never be set.
module bsg_rx
  import bsg_pkg::*;
#(
  parameter int         SYM_LEN   = 8,
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input  logic       SYS_CLK,
  input  logic       SYS_RST_N,
  input  logic [7:0] RX_IN,
  input  logic       RX_STB,
  output logic       BSG_INT,
  bsg_rx_if.slave    bus
);

  localparam logic [7:0] LAST_CNT = 8'(SYM_LEN - 1);
  localparam logic [7:0] MID_CNT  = 8'(SYM_LEN / 2);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_shadow0, r_shadow1;
  logic [7:0] r_data0, r_data1;
  logic [7:0] r_dout, w_rd_data;
  logic       r_rxen, r_intmsk, r_intflag, r_overrun, r_frameerr, r_int;
  logic       w_lat0, w_lat1, w_commit, w_ferr_set, w_mismatch;
  logic       w_status, w_wr_ctrl;
  logic [7:0] w_bin0, w_bin1;
  logic       w_unused_bits;

  assign w_status      = (r_state != ST_IDLE);
  assign w_wr_ctrl     = !bus.we && (bus.addr == ADDR_CONTROL);
  assign w_unused_bits = ^{bus.Data_in[7:6], bus.Data_in[3]};

  gray_decoder u_dec0 (.i_gray(r_shadow0), .o_bin(w_bin0));
  gray_decoder u_dec1 (.i_gray(r_shadow1), .o_bin(w_bin1));

`ifdef BSG_RX_STABLE_CHK_EN
  logic [7:0] r_first;

  // Capture the first strobe of each data symbol as its reference value.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_first <= 8'h00;
    end else if (RX_STB && r_rxen && (r_cnt == 8'd0) &&
                 ((r_state == ST_DATA0) || (r_state == ST_DATA1))) begin
      r_first <= RX_IN;
    end
  end

  // Flag any later strobe that differs from the symbol's reference value.
  always_comb begin
    w_mismatch = 1'b0;
    if (RX_STB) begin
      if (r_state == ST_SYNC) begin
        w_mismatch = (RX_IN != SYNC_WORD);
      end else if (((r_state == ST_DATA0) || (r_state == ST_DATA1)) &&
                   (r_cnt != 8'd0)) begin
        w_mismatch = (RX_IN != r_first);
      end else begin
        w_mismatch = 1'b0;
      end
    end else begin
      w_mismatch = 1'b0;
    end
  end
`else
  assign w_mismatch = 1'b0;
`endif

  // Next-state, strobe counter and per-cycle action decode for the framer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lat0      = 1'b0;
    w_lat1      = 1'b0;
    w_commit    = 1'b0;
    w_ferr_set  = 1'b0;
    if (!r_rxen && (r_state != ST_IDLE)) begin
      // Disabling the receiver abandons the frame without side effects.
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_rxen && RX_STB && (RX_IN == SYNC_WORD)) begin
            w_state_nxt = ST_SYNC;
            w_cnt_nxt   = 8'd1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_SYNC, ST_DATA0, ST_DATA1: begin
          if (!RX_STB) begin
            w_state_nxt = r_state;
          end else if (w_mismatch) begin
            w_ferr_set  = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_lat0 = (r_state == ST_DATA0) && (r_cnt == MID_CNT);
            w_lat1 = (r_state == ST_DATA1) && (r_cnt == MID_CNT);
            if (r_cnt == LAST_CNT) begin
              w_cnt_nxt = 8'd0;
              if (r_state == ST_SYNC) begin
                w_state_nxt = ST_DATA0;
              end else if (r_state == ST_DATA0) begin
                w_state_nxt = ST_DATA1;
              end else begin
                w_state_nxt = ST_COMMIT;
              end
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end
        end
        ST_COMMIT: begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // Framer state, strobe counter and mid-symbol shadow registers.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
      r_shadow0 <= 8'h00;
      r_shadow1 <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_lat0) r_shadow0 <= RX_IN;
      if (w_lat1) r_shadow1 <= RX_IN;
    end
  end

  // CONTROL and data registers; hardware set beats a same-cycle bus clear.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_rxen     <= 1'b0;
      r_intmsk   <= 1'b0;
      r_intflag  <= 1'b0;
      r_overrun  <= 1'b0;
      r_frameerr <= 1'b0;
      r_data0    <= 8'h00;
      r_data1    <= 8'h00;
    end else begin
      if (w_wr_ctrl) begin
        r_rxen   <= bus.Data_in[CTRL_RXENABLE];
        r_intmsk <= bus.Data_in[CTRL_INTMSK];
      end
      if (w_commit) begin
        r_intflag <= 1'b1;
        r_data0   <= w_bin0;
        r_data1   <= w_bin1;
      end else if (w_wr_ctrl && !bus.Data_in[CTRL_INTFLAG]) begin
        r_intflag <= 1'b0;
      end
      if (w_commit && r_intflag) begin
        r_overrun <= 1'b1;
      end else if (w_wr_ctrl && !bus.Data_in[CTRL_OVERRUN]) begin
        r_overrun <= 1'b0;
      end
      if (w_ferr_set) begin
        r_frameerr <= 1'b1;
      end else if (w_wr_ctrl && !bus.Data_in[CTRL_FRAMEERR]) begin
        r_frameerr <= 1'b0;
      end
    end
  end

  // Read data selection by address.
  always_comb begin
    w_rd_data = 8'h00;
    case (bus.addr)
      ADDR_CONTROL: w_rd_data = {2'b00, r_frameerr, r_overrun, w_status,
                                 r_intflag, r_intmsk, r_rxen};
      ADDR_DATA0:   w_rd_data = r_data0;
      ADDR_DATA1:   w_rd_data = r_data1;
      default:      w_rd_data = 8'h00;
    endcase
  end

  // Registered read port and interrupt output.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_dout <= 8'h00;
      r_int  <= 1'b0;
    end else begin
      if (bus.we) r_dout <= w_rd_data;
      r_int <= r_intmsk & r_intflag;
    end
  end

  assign bus.Data_out = r_dout;
  assign BSG_INT      = r_int;

endmodule

// File: tb/tb_bsg_rx.sv
// Directed testbench for bsg_rx with a read scoreboard: each issued read
// pushes its expected value, and a monitor compares Data_out one cycle later.
module tb_bsg_rx;

  logic       SYS_CLK;
  logic       SYS_RST_N;
  logic [7:0] RX_IN;
  logic       RX_STB;
  logic       BSG_INT;

  bsg_rx_if bus ();

  bsg_rx dut (
    .SYS_CLK  (SYS_CLK),
    .SYS_RST_N(SYS_RST_N),
    .RX_IN    (RX_IN),
    .RX_STB   (RX_STB),
    .BSG_INT  (BSG_INT),
    .bus      (bus)
  );

  int tests_run;
  int tests_failed;

  logic       rd_req;
  logic       rd_chk;
  logic [7:0] exp_q[$];
  logic [7:0] addr_q[$];
  logic [7:0] frame_v[0:23];
  logic [7:0] exp_d0, exp_d1;

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  // A read sampled on this edge produces data that is checked at the next negedge.
  always @(posedge SYS_CLK) rd_chk <= rd_req;

  // Scoreboard monitor for registered read data.
  always @(negedge SYS_CLK) begin
    logic [7:0] e, a;
    if (rd_chk) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL read_unexpected: Data_out=%02h with no expected entry", bus.Data_out);
      end else begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if (bus.Data_out !== e) begin
          tests_failed++;
          $display("FAIL read_addr_%02h: got %02h expected %02h", a, bus.Data_out, e);
        end
      end
    end
  end

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    bus.addr = a;
    bus.we   = 1'b1;
    rd_req   = 1'b1;
    exp_q.push_back(e);
    addr_q.push_back(a);
    @(negedge SYS_CLK);
    rd_req   = 1'b0;
    bus.addr = 8'h00;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.addr    = a;
    bus.Data_in = d;
    bus.we      = 1'b0;
    @(negedge SYS_CLK);
    bus.we   = 1'b1;
    bus.addr = 8'h00;
  endtask

  task automatic check_int(input string nm, input logic e);
    tests_run++;
    if (BSG_INT !== e) begin
      tests_failed++;
      $display("FAIL %s: BSG_INT=%b expected %b", nm, BSG_INT, e);
    end
  endtask

  task automatic strobe(input logic [7:0] v);
    RX_IN  = v;
    RX_STB = 1'b1;
    @(negedge SYS_CLK);
    RX_STB = 1'b0;
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      strobe(frame_v[i]);
      repeat (3) @(negedge SYS_CLK);
    end
  endtask

  task automatic fill(input logic [7:0] s, input logic [7:0] d0, input logic [7:0] d1);
    for (int i = 0; i < 8; i++) begin
      frame_v[i]      = s;
      frame_v[i + 8]  = d0;
      frame_v[i + 16] = d1;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rd_req       = 1'b0;
    SYS_RST_N    = 1'b0;
    RX_IN        = 8'h00;
    RX_STB       = 1'b0;
    bus.Data_in  = 8'h00;
    bus.addr     = 8'h00;
    bus.we       = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    check_int("reset_int", 1'b0);
    SYS_RST_N = 1'b1;
    @(negedge SYS_CLK);

    // Reset values and unmapped address.
    rd(8'h00, 8'h00);
    rd(8'h01, 8'h00);
    rd(8'h02, 8'h00);
    rd(8'h07, 8'h00);

    // Basic frame: 22 -> 3C, C1 -> 81.
    wr(8'h00, 8'h01);
    fill(8'hA5, 8'h22, 8'hC1);
    send_range(0, 23);
    rd(8'h01, 8'h3C);
    rd(8'h02, 8'h81);
    rd(8'h00, 8'h05);
    rd(8'h07, 8'h00);
    wr(8'h00, 8'h01);
    rd(8'h00, 8'h01);

    // Interrupt timing with INTMSK set: 0F -> 0A, F0 -> A0.
    wr(8'h00, 8'h03);
    fill(8'hA5, 8'h0F, 8'hF0);
    send_range(0, 22);
    strobe(frame_v[23]);
    check_int("int_in_commit", 1'b0);
    @(negedge SYS_CLK);
    check_int("int_at_commit_edge", 1'b0);
    @(negedge SYS_CLK);
    check_int("int_rise", 1'b1);
    rd(8'h00, 8'h07);
    rd(8'h01, 8'h0A);
    rd(8'h02, 8'hA0);
    wr(8'h00, 8'h03);
    check_int("int_hold_after_clear", 1'b1);
    @(negedge SYS_CLK);
    check_int("int_cleared", 1'b0);

    // Two frames without clearing INTFLAG raise OVERRUN; second frame wins.
    fill(8'hA5, 8'h22, 8'hC1);
    send_range(0, 23);
    fill(8'hA5, 8'h0F, 8'hF0);
    send_range(0, 23);
    rd(8'h00, 8'h17);
    rd(8'h01, 8'h0A);
    rd(8'h02, 8'hA0);
    check_int("int_overrun", 1'b1);
    wr(8'h00, 8'h03);
    rd(8'h00, 8'h03);
    exp_d0 = 8'h0A;
    exp_d1 = 8'hA0;

    // Corrupt the third sample of DATA0.
    fill(8'hA5, 8'h22, 8'hC1);
    frame_v[10] = 8'h00;
    send_range(0, 23);
`ifdef BSG_RX_STABLE_CHK_EN
    rd(8'h00, 8'h23);
    rd(8'h01, 8'h0A);
    rd(8'h02, 8'hA0);
`else
    rd(8'h00, 8'h07);
    rd(8'h01, 8'h3C);
    rd(8'h02, 8'h81);
    exp_d0 = 8'h3C;
    exp_d1 = 8'h81;
`endif
    wr(8'h00, 8'h03);
    rd(8'h00, 8'h03);

    // Drop RXENABLE in the middle of DATA1: frame discarded, nothing changes.
    fill(8'hA5, 8'h55, 8'hAA);
    send_range(0, 18);
    rd(8'h00, 8'h0B);
    wr(8'h00, 8'h02);
    @(negedge SYS_CLK);
    rd(8'h00, 8'h02);
    rd(8'h01, exp_d0);
    rd(8'h02, exp_d1);

    // Asynchronous reset mid-frame clears everything.
    wr(8'h00, 8'h03);
    send_range(0, 12);
    #2 SYS_RST_N = 1'b0;
    @(negedge SYS_CLK);
    check_int("int_in_reset", 1'b0);
    SYS_RST_N = 1'b1;
    @(negedge SYS_CLK);
    rd(8'h00, 8'h00);
    rd(8'h01, 8'h00);
    rd(8'h02, 8'h00);

    repeat (3) @(negedge SYS_CLK);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d reads unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bsg_rx.md
# bsg_rx

Receive-side counterpart of the BSG signal generator. It samples the 8-bit modulated symbol stream produced by a BSG transmitter and frames it into a sync symbol followed by two data symbols. Each data symbol is Gray-decoded back to binary and latched into two data registers, with an interrupt raised on every completed frame. It sits on the same AMBA-style byte register bus as the transmitter.

## Interface
- `SYM_LEN`, default 8: strobes per symbol; legal range 2..255.
- `SYNC_WORD`, default 8'hA5: frame-start symbol value.
- `SYS_CLK`, in, 1: system clock; all logic on its rising edge.
- `SYS_RST_N`, in, 1: reset, asynchronous, active-low.
- `RX_IN`, in, 8: modulated symbol stream, as on the transmitter's `OUT`.
- `RX_STB`, in, 1: one-cycle sample strobe, one per transmit-clock period; `RX_IN` is sampled only when it is high.
- `BSG_INT`, out, 1: interrupt, equal to INTMSK & INTFLAG.
- `Data_in`, in, 8: bus write data.
- `addr`, in, 8: register address.
- `Data_out`, out, 8: bus read data.
- `we`, in, 1: access type; 0 = write, 1 = read.

## Operation
- Registers:
  - 8'h00 CONTROL:
    - bit0 RXENABLE (rw).
    - bit1 INTMSK (rw).
    - bit2 INTFLAG: set by hardware; writing 0 clears it, writing 1 has no effect.
    - bit3 STATUS (ro): 1 while a frame is in progress.
    - bit4 OVERRUN: set by hardware, write 0 to clear.
    - bit5 FRAMEERR: set by hardware, write 0 to clear.
    - bits 7:6 read 0.
  - 8'h01 DATA_0 (ro), 8'h02 DATA_1 (ro).
  - Other addresses read 8'h00; writes to them are ignored.
- FSM states: IDLE, SYNC, DATA0, DATA1, COMMIT. A strobe counter `cnt` runs from 0 to SYM_LEN-1.
  - IDLE: if RXENABLE=1, RX_STB=1 and RX_IN==SYNC_WORD, then go to SYNC with cnt=1 and STATUS=1.
  - SYNC: on each strobe cnt increments. When cnt wraps from SYM_LEN-1, go to DATA0 with cnt=0.
  - DATA0/DATA1: the strobe at cnt==SYM_LEN/2 (integer division) latches RX_IN into a shadow register. At the wrap, DATA0 goes to DATA1 and DATA1 goes to COMMIT.
  - COMMIT: lasts one cycle.
    - Writes gray_decode(shadow0) to DATA_0 and gray_decode(shadow1) to DATA_1.
    - If INTFLAG was already 1, sets OVERRUN; the data is overwritten regardless.
    - Sets INTFLAG, clears STATUS, returns to IDLE.
- Gray decode: b[7]=g[7]; b[i]=b[i+1]^g[i].
- RXENABLE=0 in any non-IDLE state forces IDLE on the next edge. The frame is discarded, STATUS=0, and data registers and flags are untouched.
- A bus write clearing INTFLAG in the same cycle as COMMIT: the hardware set wins, and INTFLAG=1. The same rule applies to OVERRUN and FRAMEERR.
- Sync symbols inside a frame are not re-detected; frames are strictly back-to-back or separated by idle.

## Timing
- Reset values:
  - Data_out=0, BSG_INT=0.
  - CONTROL=0, DATA_0=0, DATA_1=0.
  - FSM in IDLE with cnt=0.
- Reset mid-frame aborts immediately (asynchronous).
- Writes take effect on the rising edge where `we`=0. The write to CONTROL is visible on BSG_INT the next cycle.
- Reads: Data_out is registered. It is valid the cycle after `addr` is sampled with `we`=1 and holds its value while `we`=0.
- Frame latency: COMMIT occurs in the cycle after the strobe that ends DATA1, i.e. 3·SYM_LEN strobes after the first sync strobe. DATA_x and INTFLAG update on the COMMIT edge, and BSG_INT rises one cycle later if INTMSK=1.
- RX_STB is ignored in COMMIT; the transmit clock is always at least 2× slower than SYS_CLK.

## Configuration
- `BSG_RX_STABLE_CHK_EN` defined:
  - Every strobe of a symbol after the first must equal the first sample of that symbol; in SYNC that means equal to SYNC_WORD.
  - Any mismatch sets FRAMEERR, discards the frame (no data, INTFLAG or OVERRUN update) and returns to IDLE.
- Undefined: only the mid-symbol sample is used, and FRAMEERR is tied to 0 and cannot be set.

## Structure
- `bsg_pkg` holds:
  - Register address localparams (8'h00/01/02).
  - CONTROL bit-index constants.
  - The FSM state enum (typedef).
- Sub-module `gray_decoder` (8-bit, combinational), the inverse of the transmitter's `encoder`. It is instantiated twice, or once on a muxed shadow register.

## Test plan
- Enable (write 8'h01 to 8'h00), send A5×8, 22×8, C1×8 → DATA_0=8'h3C and DATA_1=8'h81 after COMMIT; CONTROL reads 8'h05.
- Same frame with INTMSK=1 → BSG_INT rises one cycle after COMMIT. Writing 8'h03 to CONTROL clears it next cycle.
- Two frames without clearing INTFLAG → OVERRUN=1 and data equals the second frame.
- With `BSG_RX_STABLE_CHK_EN`, corrupt the 3rd sample of DATA0 → FRAMEERR=1, DATA_0/1 unchanged, INTFLAG=0. Without the macro → the frame is accepted and FRAMEERR=0.
- Drop RXENABLE mid-DATA1 → STATUS=0 next cycle and no register changes. Assert SYS_RST_N=0 mid-frame → all registers read 8'h00.
- Reads of addr 8'h07 → 8'h00. Back-to-back read of 8'h01 then 8'h02 → Data_out follows with one-cycle latency.
